// File: rtl/qk_score.sv
// Attention-score stage: S[j] = sat(Q . K[j] * SCALE), one query row against NUM keys.
// Build option QK_SCORE_ROUND_EN selects round-half-up instead of floor on the final shift.
module qk_score #(
   parameter int D_W   = 16,
   parameter int FRAC  = 13,
   parameter int NUM   = 4,
   parameter int DIM   = 16,
   parameter int SCALE = 2048
) (
   input  logic                     I_CLK,
   input  logic                     I_RST_N,
   input  logic                     I_START,
   input  logic [D_W*DIM-1:0]       I_Q,
   input  logic [D_W*DIM*NUM-1:0]   I_K,
   output logic                     O_VLD,
   output logic [D_W*NUM-1:0]       O_DATA
);

   localparam int CW = $clog2(DIM);
   localparam int AW = 2*D_W + CW;
   localparam int PW = AW + D_W;

   localparam logic signed [D_W-1:0] SCALE_S = D_W'(SCALE);
   localparam logic signed [PW-1:0]  SAT_MAX = PW'((2**(D_W-1)) - 1);
   localparam logic signed [PW-1:0]  SAT_MIN = -SAT_MAX - PW'(1);
`ifdef QK_SCORE_ROUND_EN
   localparam logic signed [PW-1:0]  RND_HALF = PW'(1) << (2*FRAC - 1);
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_SCL  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic signed [AW-1:0]    acc_q [NUM];
   logic signed [AW-1:0]    acc_d [NUM];
   logic                    vld_q, vld_d;
   logic [D_W*NUM-1:0]      data_q, data_d;

   logic signed [D_W-1:0]   q_e;
   logic signed [D_W-1:0]   k_e   [NUM];
   logic signed [2*D_W-1:0] mprod [NUM];
   logic signed [PW-1:0]    sprod [NUM];
   logic signed [PW-1:0]    rnd   [NUM];
   logic signed [PW-1:0]    sh    [NUM];
   logic [D_W*NUM-1:0]      score_v;

   // Datapath: per-key multiply of the current element, then scale/shift/saturate of acc.
   always_comb begin
      q_e     = I_Q[int'(cnt_q)*D_W +: D_W];
      score_v = '0;
      for (int j = 0; j < NUM; j++) begin
         k_e[j]   = I_K[(j*DIM + int'(cnt_q))*D_W +: D_W];
         mprod[j] = q_e * k_e[j];
         sprod[j] = PW'(acc_q[j]) * PW'(SCALE_S);
`ifdef QK_SCORE_ROUND_EN
         rnd[j]   = sprod[j] + RND_HALF;
`else
         rnd[j]   = sprod[j];
`endif
         sh[j]    = rnd[j] >>> (2*FRAC);
         if (sh[j] > SAT_MAX) begin
            score_v[j*D_W +: D_W] = SAT_MAX[D_W-1:0];
         end else if (sh[j] < SAT_MIN) begin
            score_v[j*D_W +: D_W] = SAT_MIN[D_W-1:0];
         end else begin
            score_v[j*D_W +: D_W] = sh[j][D_W-1:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      vld_d   = vld_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (I_START) begin
               state_d = ST_MAC;
               cnt_d   = '0;
               for (int j = 0; j < NUM; j++) acc_d[j] = '0;
            end
         end
         ST_MAC: begin
            if (!I_START) begin
               state_d = ST_IDLE;
            end else begin
               for (int j = 0; j < NUM; j++) acc_d[j] = acc_q[j] + AW'(mprod[j]);
               if (cnt_q == CW'(DIM-1)) begin
                  state_d = ST_SCL;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_q + CW'(1);
               end
            end
         end
         ST_SCL: begin
            // An abort here leaves the previous result in place and valid low.
            if (!I_START) begin
               state_d = ST_IDLE;
            end else begin
               data_d  = score_v;
               vld_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!I_START) begin
               state_d = ST_IDLE;
               vld_d   = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            vld_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         for (int j = 0; j < NUM; j++) acc_q[j] <= '0;
         vld_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         for (int j = 0; j < NUM; j++) acc_q[j] <= acc_d[j];
         vld_q   <= vld_d;
         data_q  <= data_d;
      end
   end

   assign O_VLD  = vld_q;
   assign O_DATA = data_q;

endmodule

// File: tb/tb_qk_score.sv
// Directed bench for qk_score at DIM=4, NUM=4: table of vectors plus abort, hold, reset and rounding sequences.
module tb_qk_score;

   logic          clk;
   logic          rst_n;
   logic          start_a, start_b;
   logic [63:0]   iq;
   logic [255:0]  ik;
   logic          vld_a, vld_b;
   logic [63:0]   data_a, data_b;

   int checks   = 0;
   int failures = 0;

   qk_score #(.D_W(16), .FRAC(13), .NUM(4), .DIM(4), .SCALE(4096)) dut (
      .I_CLK(clk), .I_RST_N(rst_n), .I_START(start_a), .I_Q(iq), .I_K(ik),
      .O_VLD(vld_a), .O_DATA(data_a)
   );

   qk_score #(.D_W(16), .FRAC(13), .NUM(4), .DIM(4), .SCALE(8192)) dut_r (
      .I_CLK(clk), .I_RST_N(rst_n), .I_START(start_b), .I_Q(iq), .I_K(ik),
      .O_VLD(vld_b), .O_DATA(data_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [63:0]  q;
      logic [255:0] k;
      logic [63:0]  exp;
   } vec_t;

   vec_t tbl [3];

   function automatic logic [63:0] p4(input int e0, input int e1, input int e2, input int e3);
      p4 = {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // Raise start on dut a and count edges until valid (0 means the budget ran out).
   task automatic run_a(input logic [63:0] q, input logic [255:0] k, output int lat);
      iq = q;
      ik = k;
      start_a = 1'b1;
      lat = 0;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk); #1;
         if (vld_a) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic release_a(input logic [63:0] held);
      start_a = 1'b0;
      @(posedge clk); #1;
      chk("release_vld", 64'(vld_a), 64'd0);
      chk("release_data", data_a, held);
   endtask

   int   lat;
   logic bad;
   logic [63:0] held;
   logic [63:0] basic_q, sat_q, mix_q;
   logic [255:0] basic_k, sat_k, mix_k;

   initial begin
      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; iq = '0; ik = '0;

      basic_q = p4(8192, 8192, 8192, 8192);
      basic_k = {p4(0, 0, 0, 0), p4(4096, 4096, 4096, 4096),
                 p4(-8192, -8192, -8192, -8192), p4(8192, 8192, 8192, 8192)};
      sat_q   = p4(24576, 24576, 24576, 24576);
      sat_k   = {p4(0, 0, 0, 0), p4(0, 0, 0, 0),
                 p4(-24576, -24576, -24576, -24576), p4(24576, 24576, 24576, 24576)};
      mix_q   = p4(8192, -8192, 4096, 0);
      mix_k   = {p4(0, 0, -24576, 0), p4(-8192, 0, 0, 24576),
                 p4(4096, 4096, -4096, 8192), p4(8192, 8192, 8192, 8192)};

      tbl[0] = '{basic_q, basic_k, p4(16384, -16384, 8192, 0)};
      tbl[1] = '{sat_q,   sat_k,   p4(32767, -32768, 0, 0)};
      tbl[2] = '{mix_q,   mix_k,   p4(2048, -1024, -4096, -6144)};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_vld", 64'(vld_a), 64'd0);
      chk("reset_data", data_a, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 3; i++) begin
         run_a(tbl[i].q, tbl[i].k, lat);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd6);
         chk($sformatf("vec%0d_data", i), data_a, tbl[i].exp);
         if (i == 0) begin
            bad = 1'b0;
            repeat (10) begin
               @(posedge clk); #1;
               if (vld_a !== 1'b1 || data_a !== tbl[0].exp) bad = 1'b1;
            end
            chk("hold_stable", 64'(bad), 64'd0);
         end
         release_a(tbl[i].exp);
      end

      // Abort at cnt=2 with mixed vectors, then a fresh basic request.
      iq = mix_q; ik = mix_k; start_a = 1'b1;
      bad = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (vld_a) bad = 1'b1;
      end
      start_a = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (vld_a) bad = 1'b1;
      end
      chk("abort_no_vld", 64'(bad), 64'd0);
      chk("abort_data_kept", data_a, tbl[2].exp);
      run_a(basic_q, basic_k, lat);
      chk("fresh_latency", 64'(lat), 64'd6);
      chk("fresh_data", data_a, tbl[0].exp);

      // Asynchronous reset while in DONE.
      #3 rst_n = 1'b0;
      #1;
      chk("rst_done_vld", 64'(vld_a), 64'd0);
      chk("rst_done_data", data_a, 64'd0);
      start_a = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_a(mix_q, mix_k, lat);
      chk("pre_mac_rst_data", data_a, tbl[2].exp);
      start_a = 1'b0;
      @(posedge clk); #1;

      // Asynchronous reset in the middle of MAC.
      iq = basic_q; ik = basic_k; start_a = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mac_vld", 64'(vld_a), 64'd0);
      chk("rst_mac_data", data_a, 64'd0);
      start_a = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_a(sat_q, sat_k, lat);
      chk("post_rst_latency", 64'(lat), 64'd6);
      chk("post_rst_data", data_a, tbl[1].exp);
      release_a(tbl[1].exp);

      // Exact half-LSB results on the SCALE=1.0 instance.
      iq = p4(1, 0, 0, 0);
      ik = {p4(0, 0, 0, 0), p4(0, 0, 0, 0), p4(-4096, 0, 0, 0), p4(4096, 0, 0, 0)};
      start_b = 1'b1;
      lat = 0;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk); #1;
         if (vld_b) begin
            lat = n;
            break;
         end
      end
      chk("round_latency", 64'(lat), 64'd6);
`ifdef QK_SCORE_ROUND_EN
      chk("round_data", data_b, p4(1, 0, 0, 0));
`else
      chk("round_data", data_b, p4(0, -1, 0, 0));
`endif
      start_b = 1'b0;
      @(posedge clk); #1;
      chk("round_release_vld", 64'(vld_b), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
